// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and defaults for the FIFO burst reader: FSM state, default
// widths and the counter-width helper.
package fifo_pkg;

  localparam int RAM_WIDTH_DEF = 16;
  localparam int BURST_LEN_DEF = 8;

  typedef enum logic {
    S_DATA = 1'b0,
    S_CSUM = 1'b1
  } state_t;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Downstream valid/ready beat stream with burst framing.
interface fifo_burst_reader_if #(
  parameter int W = 16
);
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_burst_reader_skid_buf2.sv
// Two-entry output buffer with push/pop/count; holds words returned by the FIFO
// until downstream accepts them.
module fifo_skid_buf2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = push_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // The credit logic upstream must make both of these impossible.
      assert (!(push && !pop && count_q == 2'd2));
      assert (!(pop && count_q == 2'd0));
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side drain stage: pulls FIFO words into BURST_LEN-beat bursts with m_last.
// Define FIFO_BURST_CSUM_EN to close every burst with an extra checksum beat.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                 read_clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [RAM_WIDTH-1:0] read_data,
  output logic                 read_en,
  output logic                 busy,
  fifo_burst_reader_if.master  m
);

  localparam int CW = cnt_w(BURST_LEN);
  localparam logic [CW-1:0] LEN  = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  state_t               state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [1:0]           buf_cnt;
  logic [1:0]           used;
  logic [RAM_WIDTH-1:0] buf_head;
  logic                 in_csum;
  logic                 pop;
  logic                 last_data;

  fifo_skid_buf2 #(.W(RAM_WIDTH)) u_buf (
    .clk       (read_clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (read_data),
    .pop       (pop),
    .head      (buf_head),
    .count     (buf_cnt)
  );

  assign in_csum   = (state_q == S_CSUM);
  assign pop       = !in_csum && (buf_cnt != 2'd0) && m.m_ready;
  assign last_data = pop && (beat_cnt_q == LAST);

  // A slot freed by this cycle's pop counts as credit so a steady stream runs at
  // one beat per cycle; a full buffer never issues, whatever the pop.
  assign used    = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
  assign read_en = rst_n && !fifo_empty && (state_q == S_DATA) && (issued_q < LEN)
                 && (buf_cnt != 2'd2) && (used < 2'd2);

  // A partially issued burst keeps busy high even while the FIFO runs dry.
  assign busy = (buf_cnt != 2'd0) || inflight_q || in_csum || (issued_q != '0);

`ifdef FIFO_BURST_CSUM_EN
  logic [RAM_WIDTH-1:0] sum_q, sum_d;

  assign m.m_valid = in_csum || (buf_cnt != 2'd0);
  assign m.m_data  = in_csum ? sum_q : buf_head;
  assign m.m_last  = in_csum;

  always_comb begin
    state_d    = state_q;
    inflight_d = read_en;
    issued_d   = issued_q + (read_en ? CW'(1) : CW'(0));
    beat_cnt_d = beat_cnt_q + (pop ? CW'(1) : CW'(0));
    sum_d      = pop ? sum_q + buf_head : sum_q;
    if (last_data) state_d = S_CSUM;
    if (in_csum && m.m_ready) begin
      state_d    = S_DATA;
      issued_d   = '0;
      beat_cnt_d = '0;
      sum_d      = '0;
    end
  end
`else
  assign m.m_valid = (buf_cnt != 2'd0);
  assign m.m_data  = buf_head;
  assign m.m_last  = (buf_cnt != 2'd0) && (beat_cnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    inflight_d = read_en;
    issued_d   = issued_q + (read_en ? CW'(1) : CW'(0));
    beat_cnt_d = beat_cnt_q + (pop ? CW'(1) : CW'(0));
    if (last_data) begin
      issued_d   = '0;
      beat_cnt_d = '0;
    end
  end
`endif

  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_DATA;
      inflight_q <= 1'b0;
      issued_q   <= '0;
      beat_cnt_q <= '0;
`ifdef FIFO_BURST_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      issued_q   <= issued_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef FIFO_BURST_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a FIFO model feeds words, the expected
// beat queue is filled as words are pushed and drained by a separate monitor.
module tb_fifo_burst_reader;

  localparam int W  = 16;
  localparam int BL = 8;
`ifdef FIFO_BURST_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int BEATS = BL + (CSUM ? 1 : 0);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] read_data  = '0;
  logic         read_en;
  logic         busy;

  fifo_burst_reader_if #(.W(W)) sif ();

  fifo_burst_reader #(.RAM_WIDTH(W), .BURST_LEN(BL)) dut (
    .read_clk   (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .read_data  (read_data),
    .read_en    (read_en),
    .busy       (busy),
    .m          (sif)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq[$];
  beat_t        exp_q[$];
  int           vectors      = 0;
  int           miscompares  = 0;
  int           acc_cnt      = 0;
  int           cyc          = 0;
  int           last_acc_cyc = 0;
  int           beat_in_burst = 0;
  bit           chk_tput     = 1'b0;
  int           word_pos     = 0;
  logic [W-1:0] running_sum  = '0;
  bit           prev_pend    = 1'b0;
  logic [W-1:0] prev_data    = '0;
  logic         prev_last    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO read port: data appears one cycle after read_en, empty flag updates mid-cycle.
  always @(posedge clk) begin
    cyc++;
    if (read_en && fq.size() > 0) read_data <= fq.pop_front();
  end
  always @(negedge clk) fifo_empty = (fq.size() == 0);

  // Monitor: compares each accepted beat with the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (prev_pend) begin
        chk("hold_valid", 32'(sif.m_valid), 32'd1);
        chk("hold_data", 32'(sif.m_data), 32'(prev_data));
        chk("hold_last", 32'(sif.m_last), 32'(prev_last));
      end
      if (dut.buf_cnt == 2'd2) chk("no_read_when_full", 32'(read_en), 32'd0);
      if (sif.m_valid && sif.m_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", sif.m_data, sif.m_last);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(sif.m_data), 32'(e.data));
          chk("beat_last", 32'(sif.m_last), 32'(e.last));
          $display("beat %0d: data=%0h last=%0b", acc_cnt, sif.m_data, sif.m_last);
        end
        if (chk_tput && beat_in_burst != 0) chk("tput_gap", 32'(cyc - last_acc_cyc), 32'd1);
        last_acc_cyc  = cyc;
        beat_in_burst = (beat_in_burst + 1) % BEATS;
        acc_cnt++;
      end
      prev_pend = sif.m_valid && !sif.m_ready;
      prev_data = sif.m_data;
      prev_last = sif.m_last;
    end else begin
      prev_pend     = 1'b0;
      beat_in_burst = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    bit lst;
    lst = (word_pos == BL - 1);
    fq.push_back(d);
    exp_q.push_back('{data: d, last: (lst && !CSUM)});
    running_sum = running_sum + d;
    if (lst && CSUM) begin
      exp_q.push_back('{data: running_sum, last: 1'b1});
    end
    if (lst) running_sum = '0;
    word_pos = (word_pos + 1) % BL;
  endtask

  task automatic wait_drain(input int budget, input bit rand_ready);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      if (rand_ready) sif.m_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    sif.m_ready = 1'b1;
    chk("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    sif.m_ready = 1'b0;

    // Reset: outputs idle, read_en held low even with a non-empty FIFO.
    for (int i = 0; i < 32; i++) push_word(W'(i));
    repeat (3) tick();
    chk("rst_m_valid", 32'(sif.m_valid), 32'd0);
    chk("rst_m_data", 32'(sif.m_data), 32'd0);
    chk("rst_m_last", 32'(sif.m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_en", 32'(read_en), 32'd0);
    rst_n = 1'b1;

    // Steady flow 0..31, one beat per cycle within each burst.
    sif.m_ready = 1'b1;
    chk_tput    = 1'b1;
    wait_drain(400, 1'b0);
    chk_tput    = 1'b0;

    // Random back-pressure over 64 words.
    for (int i = 0; i < 64; i++) push_word(W'(i));
    wait_drain(3000, 1'b1);

    // FIFO empty mid-burst: 5 words, a 20-cycle gap, then 3 more.
    for (int i = 0; i < 5; i++) push_word(W'(i));
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("busy_in_gap", 32'(busy), 32'd1);
    end
    for (int i = 5; i < 8; i++) push_word(W'(i));
    wait_drain(200, 1'b0);

    // Checksum-oriented bursts: 1..8 (sum 36) and eight 0xFFFF words (sum 0xFFF8).
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    for (int i = 0; i < 8; i++) push_word(16'hFFFF);
    wait_drain(400, 1'b0);

    // Reset after exactly three accepted beats.
    sif.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(W'(100 + i));
    repeat (6) tick();
    base = acc_cnt;
    sif.m_ready = 1'b1;
    n = 0;
    while (acc_cnt < base + 3 && n < 50) begin
      tick();
      n++;
    end
    chk("three_beats_seen", 32'(acc_cnt - base), 32'd3);
    rst_n       = 1'b0;
    sif.m_ready = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(sif.m_valid), 32'd0);
    chk("midrst_m_data", 32'(sif.m_data), 32'd0);
    chk("midrst_m_last", 32'(sif.m_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_read_en", 32'(read_en), 32'd0);
    fq.delete();
    exp_q.delete();
    word_pos    = 0;
    running_sum = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) push_word(W'(200 + i));
    sif.m_ready = 1'b1;
    wait_drain(200, 1'b0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
